// File: rtl/axil_servo_multi_ctrl_pkg.sv
// rtl/axil_servo_multi_ctrl_pkg.sv - shared constants, types and helpers for the servo controller
// Purpose: register offsets, CTRL bit positions, angle limits, bus FSM state types.
// Ports: none (package).
package axil_servo_multi_ctrl_pkg;

  typedef logic [7:0] angle_t;

  localparam int ADDR_CTRL        = 'h00;
  localparam int ADDR_STATUS      = 'h04;
  localparam int ADDR_RAMP_STEP   = 'h08;
  localparam int ADDR_TARGET_BASE = 'h10;
  localparam int ADDR_CUR_BASE    = 'h30;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_RAMP_BIT = 1;

  localparam angle_t ANGLE_MAX   = 8'd180;
  localparam angle_t ANGLE_RESET = 8'd90;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_e;

  // Out-of-range targets saturate rather than wrap.
  function automatic angle_t clamp_angle(input logic [7:0] a);
    return (a > ANGLE_MAX) ? ANGLE_MAX : a;
  endfunction

endpackage

// File: rtl/axil_servo_multi_ctrl_if.sv
// rtl/axil_servo_multi_ctrl_if.sv - AXI4-Lite register bus bundle
// Purpose: groups the AXI4-Lite channel signals of the servo controller.
// Ports: none; master modport drives requests, slave modport drives ready/response.
interface axil_servo_multi_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/axil_servo_multi_ctrl_pwm_channel.sv
// rtl/axil_servo_multi_ctrl_pwm_channel.sv - one servo channel: live angle, ramp, width latch, comparator
// Purpose: at each period start moves the live angle toward the target and latches the pulse width.
// Ports: clk_i/rst_ni clock and async reset; en_i output enable; start_i period start strobe;
//        ramp_i ramp mode; step_i degrees per period; target_i requested angle; us_cnt_i shared
//        microsecond counter; cur_o live angle; busy_o cur != target; pwm_o pulse output.
module axil_servo_multi_ctrl_pwm_channel
  import axil_servo_multi_ctrl_pkg::*;
#(
  parameter int MIN_US = 500,
  parameter int MAX_US = 2500,
  parameter int US_W   = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            start_i,
  input  logic            ramp_i,
  input  angle_t          step_i,
  input  angle_t          target_i,
  input  logic [US_W-1:0] us_cnt_i,
  output angle_t          cur_o,
  output logic            busy_o,
  output logic            pwm_o
);

  localparam int SPAN_US  = MAX_US - MIN_US;
  localparam int RESET_W  = MIN_US + (int'(ANGLE_RESET) * SPAN_US) / 180;

  angle_t          cur_q, cur_d;
  logic [US_W-1:0] width_q, width_d;
  angle_t          diff;
  angle_t          stepv;
  logic [19:0]     prod;

  always_comb begin
    cur_d   = cur_q;
    width_d = width_q;
    diff    = (cur_q < target_i) ? (target_i - cur_q) : (cur_q - target_i);
    // Clipping the step to the remaining distance keeps the ramp from overshooting.
    stepv   = (step_i < diff) ? step_i : diff;
    if (start_i) begin
      if (!ramp_i) begin
        cur_d = target_i;
      end else if (cur_q < target_i) begin
        cur_d = cur_q + stepv;
      end else begin
        cur_d = cur_q - stepv;
      end
    end
    prod = 20'(cur_d) * 20'(SPAN_US);
    if (start_i) begin
      width_d = US_W'(MIN_US) + US_W'(prod / 20'd180);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q   <= ANGLE_RESET;
      width_q <= US_W'(RESET_W);
    end else begin
      cur_q   <= cur_d;
      width_q <= width_d;
    end
  end

  assign cur_o  = cur_q;
  assign busy_o = (cur_q != target_i);
  assign pwm_o  = en_i && (us_cnt_i < width_q);

endmodule

// File: rtl/axil_servo_multi_ctrl.sv
// rtl/axil_servo_multi_ctrl.sv - N-channel servo PWM controller with AXI4-Lite register file
// Purpose: AXI4-Lite slave FSMs, CTRL/RAMP_STEP/TARGET registers, shared 1 us timebase and
//          period counter, one PWM channel per servo.
// Ports: ACLK clock; ARESETN async active-low reset; s_axi AXI4-Lite slave bundle;
//        pwm_out servo pulses; period_tick one-cycle strobe at each period start.
module axil_servo_multi_ctrl
  import axil_servo_multi_ctrl_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int CLK_HZ             = 100_000_000,
  parameter int PERIOD_US          = 20000,
  parameter int MIN_US             = 500,
  parameter int MAX_US             = 2500,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  axil_servo_multi_ctrl_if.slave s_axi,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic                   period_tick
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int PRESC = CLK_HZ / 1_000_000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int US_W  = $clog2(PERIOD_US);

  wr_state_e               wr_state_q;
  rd_state_e               rd_state_q;
  logic                    awready_q;
  logic                    bvalid_q;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [DW-1:0]           rdata_q;
  logic [DW-1:0]           rd_data;

  logic [1:0]              ctrl_q, ctrl_d;
  angle_t                  ramp_step_q, ramp_step_d;
  angle_t [NUM_CH-1:0]     target_q, target_d;
  angle_t [NUM_CH-1:0]     cur;
  logic [NUM_CH-1:0]       busy;

  logic [PW-1:0]           presc_q;
  logic [US_W-1:0]         us_cnt_q;
  logic                    period_tick_q;
  logic                    en_q, en_d, ramp_d;
  logic                    us_tick, period_wrap, period_start;

  logic                    unused_bus_bits;

  assign unused_bus_bits = ^{s_axi.s_axi_wdata[DW-1:8], s_axi.s_axi_wstrb[DW/8-1:1]};

  // Write channel: awready/wready pulse together, register updates on that handshake cycle,
  // bvalid follows and blocks further writes until bready.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (s_axi.s_axi_awvalid && s_axi.s_axi_wvalid) begin
            awready_q  <= 1'b1;
            wr_state_q <= WR_ACCEPT;
          end
        end
        WR_ACCEPT: begin
          awready_q  <= 1'b0;
          bvalid_q   <= 1'b1;
          wr_state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axi.s_axi_bready) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: begin
          awready_q  <= 1'b0;
          bvalid_q   <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Only byte lane 0 carries register bits, so only wstrb[0] gates an update.
  always_comb begin
    ctrl_d      = ctrl_q;
    ramp_step_d = ramp_step_q;
    target_d    = target_q;
    if (wr_state_q == WR_ACCEPT && s_axi.s_axi_wstrb[0]) begin
      if (s_axi.s_axi_awaddr == AW'(ADDR_CTRL)) begin
        ctrl_d = s_axi.s_axi_wdata[1:0];
      end
      if (s_axi.s_axi_awaddr == AW'(ADDR_RAMP_STEP)) begin
        ramp_step_d = s_axi.s_axi_wdata[7:0];
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (s_axi.s_axi_awaddr == AW'(ADDR_TARGET_BASE + 4 * ch)) begin
          target_d[ch] = clamp_angle(s_axi.s_axi_wdata[7:0]);
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q      <= 2'b00;
      ramp_step_q <= 8'd1;
      target_q    <= {NUM_CH{ANGLE_RESET}};
    end else begin
      ctrl_q      <= ctrl_d;
      ramp_step_q <= ramp_step_d;
      target_q    <= target_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (s_axi.s_axi_araddr == AW'(ADDR_CTRL)) begin
      rd_data = DW'(ctrl_q);
    end
    if (s_axi.s_axi_araddr == AW'(ADDR_STATUS)) begin
      rd_data = DW'(busy);
    end
    if (s_axi.s_axi_araddr == AW'(ADDR_RAMP_STEP)) begin
      rd_data = DW'(ramp_step_q);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (s_axi.s_axi_araddr == AW'(ADDR_TARGET_BASE + 4 * ch)) begin
        rd_data = DW'(target_q[ch]);
      end
      if (s_axi.s_axi_araddr == AW'(ADDR_CUR_BASE + 4 * ch)) begin
        rd_data = DW'(cur[ch]);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (s_axi.s_axi_arvalid) begin
            arready_q  <= 1'b1;
            rd_state_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b1;
          rdata_q    <= rd_data;
          rd_state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (s_axi.s_axi_rready) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: begin
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = awready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = 2'b00;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = 2'b00;

  // Period start is evaluated against the next CTRL value so that the enabling write itself
  // launches the first period: the cycle after EN rises already carries period_tick and the
  // freshly latched widths.
  assign en_q         = ctrl_q[CTRL_EN_BIT];
  assign en_d         = ctrl_d[CTRL_EN_BIT];
  assign ramp_d       = ctrl_d[CTRL_RAMP_BIT];
  assign us_tick      = en_q && (presc_q == PW'(PRESC - 1));
  assign period_wrap  = us_tick && (us_cnt_q == US_W'(PERIOD_US - 1));
  assign period_start = en_d && (!en_q || period_wrap);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_q       <= '0;
      us_cnt_q      <= '0;
      period_tick_q <= 1'b0;
    end else begin
      period_tick_q <= period_start;
      if (!en_d || !en_q) begin
        presc_q  <= '0;
        us_cnt_q <= '0;
      end else if (us_tick) begin
        presc_q  <= '0;
        us_cnt_q <= period_wrap ? '0 : us_cnt_q + 1'b1;
      end else begin
        presc_q  <= presc_q + 1'b1;
      end
    end
  end

  assign period_tick = period_tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axil_servo_multi_ctrl_pwm_channel #(
      .MIN_US (MIN_US),
      .MAX_US (MAX_US),
      .US_W   (US_W)
    ) u_ch (
      .clk_i    (ACLK),
      .rst_ni   (ARESETN),
      .en_i     (en_q),
      .start_i  (period_start),
      .ramp_i   (ramp_d),
      .step_i   (ramp_step_q),
      .target_i (target_q[g]),
      .us_cnt_i (us_cnt_q),
      .cur_o    (cur[g]),
      .busy_o   (busy[g]),
      .pwm_o    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_axil_servo_multi_ctrl.sv
// tb/tb_axil_servo_multi_ctrl.sv - directed self-checking bench for axil_servo_multi_ctrl
module tb_axil_servo_multi_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] pwm_out;
  logic       period_tick;
  int         vectors;
  int         miscompares;
  int         cyc;

  axil_servo_multi_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

  axil_servo_multi_ctrl #(
    .NUM_CH             (4),
    .CLK_HZ             (2_000_000),
    .PERIOD_US          (100),
    .MIN_US             (10),
    .MAX_US             (46),
    .C_S_AXI_ADDR_WIDTH (7),
    .C_S_AXI_DATA_WIDTH (32)
  ) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .s_axi       (bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdelay);
    int n;
    int bad;
    @(negedge clk);
    bus.s_axi_awaddr  = a;
    bus.s_axi_wdata   = d;
    bus.s_axi_wstrb   = s;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_bready  = (bdelay == 0);
    n = 0;
    while (!bus.s_axi_awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.s_axi_awready !== 1'b1 || bus.s_axi_wready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_accept addr=%h awready=%b wready=%b required 1/1", a,
               bus.s_axi_awready, bus.s_axi_wready);
    end
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    vectors++;
    if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_resp addr=%h bvalid=%b bresp=%b required 1/00", a,
               bus.s_axi_bvalid, bus.s_axi_bresp);
    end
    bad = 0;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_awready !== 1'b0) bad++;
    end
    if (bdelay > 0) begin
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL wr_bvalid_hold addr=%h bad_cycles=%0d required 0", a, bad);
      end
    end
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    bus.s_axi_araddr  = a;
    bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_accept addr=%h arready=%b required 1", a, bus.s_axi_arready);
    end
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    vectors++;
    if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_latency addr=%h rvalid=%b rresp=%b required 1/00", a,
               bus.s_axi_rvalid, bus.s_axi_rresp);
    end
    d = bus.s_axi_rdata;
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (period_tick !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (period_tick !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout waited=%0d cycles, required a period_tick", n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int bad;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    axi_read(7'h10, d);
    vectors++;
    if (d !== 32'h5A) begin miscompares++; $display("FAIL rst_target0 got=%h required=%h", d, 32'h5A); end
    axi_read(7'h00, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL rst_ctrl got=%h required=0", d); end
    axi_read(7'h08, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL rst_ramp_step got=%h required=1", d); end
    axi_read(7'h30, d);
    vectors++;
    if (d !== 32'h5A) begin miscompares++; $display("FAIL rst_cur0 got=%h required=5a", d); end
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (pwm_out !== 4'b0 || period_tick !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL rst_pwm_idle active_cycles=%0d required 0", bad); end
  endtask

  task automatic test_pwm_width();
    int hi0, hi1, hi2, extra;
    axi_write(7'h10, 32'd0, 4'hF, 0);
    axi_write(7'h14, 32'd180, 4'hF, 0);
    axi_write(7'h00, 32'd1, 4'hF, 0);
    wait_tick(400);
    hi0 = 0; hi1 = 0; hi2 = 0; extra = 0;
    for (int i = 0; i < 200; i++) begin
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
      if (i > 0 && period_tick === 1'b1) extra++;
      @(negedge clk);
    end
    vectors++;
    if (hi0 != 20) begin miscompares++; $display("FAIL width_ch0 got=%0d required=20", hi0); end
    vectors++;
    if (hi1 != 92) begin miscompares++; $display("FAIL width_ch1 got=%0d required=92", hi1); end
    vectors++;
    if (hi2 != 56) begin miscompares++; $display("FAIL width_ch2 got=%0d required=56", hi2); end
    vectors++;
    if (extra != 0 || period_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL tick_spacing extra=%0d tick_at_200=%b required 0/1", extra, period_tick);
    end
  endtask

  task automatic test_clamp_unmapped();
    logic [31:0] d;
    axi_write(7'h18, 32'd200, 4'hF, 0);
    axi_read(7'h18, d);
    vectors++;
    if (d !== 32'hB4) begin miscompares++; $display("FAIL target_clamp got=%h required=b4", d); end
    axi_write(7'h40, 32'h1234_5678, 4'hF, 0);
    axi_read(7'h40, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_cur got=%h required=0", d); end
    axi_read(7'h20, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_target got=%h required=0", d); end
  endtask

  task automatic test_ramp();
    logic [31:0] d;
    logic [31:0] exp_cur;
    logic [31:0] exp_st;
    axi_write(7'h10, 32'd90, 4'hF, 0);
    wait_tick(400);
    axi_read(7'h30, d);
    vectors++;
    if (d !== 32'd90) begin miscompares++; $display("FAIL ramp_pre_cur0 got=%0d required=90", d); end
    wait_tick(400);
    axi_write(7'h08, 32'd30, 4'hF, 0);
    axi_write(7'h00, 32'd3, 4'hF, 0);
    axi_write(7'h10, 32'd180, 4'hF, 0);
    axi_read(7'h04, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL ramp_status0 got=%h required=1", d); end
    for (int k = 1; k <= 3; k++) begin
      wait_tick(400);
      exp_cur = 32'(90 + 30 * k);
      exp_st  = (k < 3) ? 32'h1 : 32'h0;
      axi_read(7'h30, d);
      vectors++;
      if (d !== exp_cur) begin miscompares++; $display("FAIL ramp_cur0_step%0d got=%0d required=%0d", k, d, exp_cur); end
      axi_read(7'h04, d);
      vectors++;
      if (d !== exp_st) begin miscompares++; $display("FAIL ramp_status_step%0d got=%h required=%h", k, d, exp_st); end
    end
    wait_tick(400);
    axi_read(7'h30, d);
    vectors++;
    if (d !== 32'd180) begin miscompares++; $display("FAIL ramp_no_overshoot got=%0d required=180", d); end
  endtask

  task automatic test_midperiod_update();
    int tick_cyc, fall, hi, n;
    axi_write(7'h00, 32'd1, 4'hF, 0);
    wait_tick(400);
    tick_cyc = cyc;
    repeat (30) @(negedge clk);
    axi_write(7'h10, 32'd0, 4'hF, 0);
    n = 0;
    while (pwm_out[0] === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    fall = cyc - tick_cyc;
    vectors++;
    if (fall != 92) begin miscompares++; $display("FAIL midperiod_width got=%0d required=92", fall); end
    wait_tick(400);
    hi = 0;
    while (pwm_out[0] === 1'b1 && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    vectors++;
    if (hi != 20) begin miscompares++; $display("FAIL next_period_width got=%0d required=20", hi); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] d;
    wait_tick(400);
    repeat (5) @(negedge clk);
    vectors++;
    if (pwm_out[1] !== 1'b1) begin miscompares++; $display("FAIL pre_reset_pulse got=%b required=1", pwm_out[1]); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pwm_out !== 4'b0 || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_pwm got=%b tick=%b required=0000/0", pwm_out, period_tick);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    axi_read(7'h00, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL rst2_ctrl got=%h required=0", d); end
    axi_read(7'h08, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL rst2_ramp_step got=%h required=1", d); end
    axi_read(7'h14, d);
    vectors++;
    if (d !== 32'h5A) begin miscompares++; $display("FAIL rst2_target1 got=%h required=5a", d); end
    axi_read(7'h34, d);
    vectors++;
    if (d !== 32'h5A) begin miscompares++; $display("FAIL rst2_cur1 got=%h required=5a", d); end
    axi_read(7'h04, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL rst2_status got=%h required=0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    axi_write(7'h14, 32'd45, 4'hF, 10);
    axi_write(7'h1C, 32'd135, 4'hF, 10);
    axi_write(7'h08, 32'h77, 4'h0, 0);
    axi_read(7'h14, d);
    vectors++;
    if (d !== 32'd45) begin miscompares++; $display("FAIL b2b_target1 got=%0d required=45", d); end
    axi_read(7'h1C, d);
    vectors++;
    if (d !== 32'd135) begin miscompares++; $display("FAIL b2b_target3 got=%0d required=135", d); end
    axi_read(7'h08, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL wstrb_zero_dropped got=%h required=1", d); end
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst_n             = 1'b0;
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;
    test_reset();
    test_pwm_width();
    test_clamp_unmapped();
    test_ramp();
    test_midperiod_update();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
